adc_scan_sequencer: RTL and testbench

Scheduler that shares the single serial ADC interface block among eight analog channels. It round-robins over a programmable channel mask, lets one-shot software requests pre-empt the scan, and drives the interface's enable and three channel-select bits. It captures each 10-bit result into a per-channel result bank and reports timeouts. It sits between the control registers and the ADC interface, in the same `clk` domain.

---
 rtl/adc_scan_sequencer_pkg.sv | 17 +
 rtl/adc_scan_sequencer_if.sv | 12 +
 rtl/adc_scan_sequencer_rr_pick.sv | 29 ++
 rtl/adc_scan_sequencer.sv | 126 ++++++++++++
 tb/tb_adc_scan_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/adc_scan_sequencer_pkg.sv
// Shared constants and FSM state type for the ADC scan sequencer.
package adc_scan_sequencer_pkg;

  localparam int unsigned ADC_NCH     = 8;
  localparam int unsigned ADC_DW      = 10;
  localparam int unsigned ADC_CH_W    = 3;
  localparam int unsigned ADC_TIMEOUT = 40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_CONVERT = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4
  } adc_state_t;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Handshake between the scan sequencer and the serial ADC interface block.
interface adc_scan_sequencer_if;
  import adc_scan_sequencer_pkg::*;

  logic                adc_enable;
  logic [ADC_CH_W-1:0] adc_ch;
  logic                adc_done;
  logic [ADC_DW-1:0]   adc_data;

  modport master (output adc_enable, adc_ch, input adc_done, adc_data);
  modport slave  (input adc_enable, adc_ch, output adc_done, adc_data);
endinterface

// File: rtl/adc_scan_sequencer_rr_pick.sv
// Combinational round-robin finder: first set mask bit strictly after ptr, wrapping.
module adc_scan_sequencer_rr_pick
  import adc_scan_sequencer_pkg::*;
#(
  parameter int unsigned NCH  = ADC_NCH,
  parameter int unsigned CH_W = ADC_CH_W
) (
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] pick,
  output logic            found
);

  int unsigned idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = (32'(ptr) + i) % NCH;
      if (!found && mask[CH_W'(idx)]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin / one-shot scheduler for the shared serial ADC, with per-channel result bank.
module adc_scan_sequencer
  import adc_scan_sequencer_pkg::*;
#(
  parameter int unsigned NCH     = ADC_NCH,
  parameter int unsigned DW      = ADC_DW,
  parameter int unsigned TIMEOUT = ADC_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic [NCH-1:0]      ch_mask,
  input  logic                sw_req,
  input  logic [ADC_CH_W-1:0] sw_ch,
  output logic                sw_ack,
  adc_scan_sequencer_if.master adc,
  output logic                res_valid,
  output logic [ADC_CH_W-1:0] res_ch,
  output logic [DW-1:0]       res_data,
  input  logic [ADC_CH_W-1:0] rd_ch,
  output logic [DW-1:0]       rd_data,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned CH_W  = ADC_CH_W;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  adc_state_t       state_q, state_d;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  pick;
  logic             pick_found;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    bank [NCH];
  logic             grant_sw, grant_scan, done_hit, abort;

  adc_scan_sequencer_rr_pick #(.NCH(NCH), .CH_W(CH_W)) u_rr_pick (
    .mask  (ch_mask),
    .ptr   (rr_ptr),
    .pick  (pick),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // One-shot requests win at the IDLE decision; a running frame is never pre-empted.
  always_comb begin
    state_d    = state_q;
    grant_sw   = 1'b0;
    grant_scan = 1'b0;
    done_hit   = 1'b0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sw_req) begin
          grant_sw = 1'b1;
          state_d  = ST_SETUP;
        end else if (scan_en && pick_found) begin
          grant_scan = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_CONVERT;
      ST_CONVERT: begin
        if (adc.adc_done) begin
          done_hit = 1'b1;
          state_d  = ST_CAPTURE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_CAPTURE: state_d = ST_GAP;
      ST_GAP:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Enable covers CONVERT and CAPTURE so data_out stays valid while it is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_ack         <= 1'b0;
      res_valid      <= 1'b0;
      res_ch         <= '0;
      res_data       <= '0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      adc.adc_enable <= 1'b0;
      adc.adc_ch     <= '0;
      rr_ptr         <= CH_W'(NCH - 1);
      cnt_q          <= '0;
    end else begin
      sw_ack         <= grant_sw;
      res_valid      <= done_hit;
      busy           <= (state_d != ST_IDLE);
      adc.adc_enable <= (state_d == ST_CONVERT) || (state_d == ST_CAPTURE);
      if (grant_sw) begin
        adc.adc_ch <= sw_ch;
      end else if (grant_scan) begin
        adc.adc_ch <= pick;
        rr_ptr     <= pick;
      end
      if (state_q == ST_CONVERT && state_d == ST_CONVERT) cnt_q <= cnt_q + CNT_W'(1);
      else                                                 cnt_q <= '0;
      if (done_hit) begin
        res_ch   <= adc.adc_ch;
        res_data <= adc.adc_data;
      end
      if (abort) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) bank[i] <= '0;
    end else if (state_q == ST_CAPTURE) begin
      bank[adc.adc_ch] <= adc.adc_data;
    end
  end

  assign rd_data = bank[rd_ch];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed scoreboard bench for adc_scan_sequencer with a behavioural falling-edge ADC.
module tb_adc_scan_sequencer;
  import adc_scan_sequencer_pkg::*;

  localparam int MODE_FIXED = 0;
  localparam int MODE_CHX   = 1;
  localparam int MODE_NEVER = 2;

  typedef struct {
    logic [2:0] ch;
    logic [9:0] data;
  } exp_t;

  logic       clk, rst, scan_en, sw_req, sw_ack;
  logic [7:0] ch_mask;
  logic [2:0] sw_ch, res_ch, rd_ch;
  logic [9:0] res_data, rd_data;
  logic       res_valid, busy, timeout_err;

  adc_scan_sequencer_if bus();

  adc_scan_sequencer dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .ch_mask(ch_mask),
    .sw_req(sw_req), .sw_ch(sw_ch), .sw_ack(sw_ack), .adc(bus),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
    .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy), .timeout_err(timeout_err)
  );

  int   total = 0;
  int   bad   = 0;
  int   mode  = MODE_FIXED;
  int   mcnt  = 0;
  exp_t q[$];
  bit   prev_en = 1'b0;
  logic [2:0] held_ch = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] ch, input logic [9:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    q.push_back(e);
  endtask

  // Behavioural ADC: done + data 18 falling edges after enable rises, cleared when enable drops.
  always @(negedge clk) begin
    if (bus.adc_enable !== 1'b1) begin
      mcnt         <= 0;
      bus.adc_done <= 1'b0;
      bus.adc_data <= '0;
    end else if (mode != MODE_NEVER) begin
      if (mcnt == 17) begin
        bus.adc_done <= 1'b1;
        bus.adc_data <= (mode == MODE_FIXED) ? 10'h155 : 10'(32'(bus.adc_ch) * 100);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  // Scoreboard pop on each result, plus channel stability while enable is high.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_res_valid", 32'(res_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("res_ch", 32'(res_ch), 32'(e.ch));
        check("res_data", 32'(res_data), 32'(e.data));
      end
    end
    if (bus.adc_enable === 1'b1) begin
      if (!prev_en) held_ch = bus.adc_ch;
      else          check("adc_ch_stable", 32'(bus.adc_ch), 32'(held_ch));
    end
    prev_en = (bus.adc_enable === 1'b1);
  end

  initial begin
    int n;
    int low;
    bit seen;
    rst = 1'b1; scan_en = 1'b1; ch_mask = 8'h00; sw_req = 1'b0; sw_ch = '0; rd_ch = '0;
    mode = MODE_FIXED;
    repeat (3) tick();
    rst = 1'b0;
    repeat (30) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_enable", 32'(bus.adc_enable), 32'd0);
    check("idle_sw_ack", 32'(sw_ack), 32'd0);
    check("idle_res_valid", 32'(res_valid), 32'd0);
    check("idle_timeout", 32'(timeout_err), 32'd0);
    check("idle_res_data", 32'(res_data), 32'd0);
    check("idle_rd_data", 32'(rd_data), 32'd0);

    // Round-robin over mask 1010_0100
    mode = MODE_CHX;
    push_exp(3'd2, 10'd200);
    push_exp(3'd5, 10'd500);
    push_exp(3'd7, 10'd700);
    ch_mask = 8'b1010_0100;
    n = 0;
    while (q.size() != 0 && n < 300) begin tick(); n++; end
    check("wait_scan_drain", 32'(n < 300), 32'd1);
    rd_ch = 3'd5; #1;
    check("rd_ch5", 32'(rd_data), 32'd500);

    // One-shot request raised during the following ch2 frame
    push_exp(3'd2, 10'd200);
    push_exp(3'd6, 10'd600);
    push_exp(3'd5, 10'd500);
    n = 0;
    while (!(bus.adc_enable === 1'b1 && bus.adc_ch == 3'd2) && n < 50) begin tick(); n++; end
    check("wait_ch2_convert", 32'(n < 50), 32'd1);
    sw_ch = 3'd6; sw_req = 1'b1;
    n = 0;
    while (sw_ack !== 1'b1 && n < 60) begin tick(); n++; end
    check("wait_sw_ack", 32'(n < 60), 32'd1);
    check("sw_ack_ch", 32'(bus.adc_ch), 32'd6);
    check("sw_after_ch2", 32'(q.size()), 32'd2);
    sw_req = 1'b0;
    tick();
    check("sw_ack_pulse", 32'(sw_ack), 32'd0);
    n = 0;
    while (q.size() != 0 && n < 200) begin tick(); n++; end
    check("wait_sw_drain", 32'(n < 200), 32'd1);
    scan_en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin tick(); n++; end
    check("wait_idle1", 32'(n < 50), 32'd1);
    rd_ch = 3'd6; #1; check("rd_ch6", 32'(rd_data), 32'd600);
    rd_ch = 3'd7; #1; check("rd_ch7", 32'(rd_data), 32'd700);
    rd_ch = 3'd2; #1; check("rd_ch2", 32'(rd_data), 32'd200);
    rd_ch = 3'd0; #1; check("rd_ch0", 32'(rd_data), 32'd0);

    // Timeout: ADC never answers
    check("pre_timeout_err", 32'(timeout_err), 32'd0);
    mode = MODE_NEVER; ch_mask = 8'h09; scan_en = 1'b1;
    n = 0;
    while (bus.adc_enable !== 1'b1 && n < 20) begin tick(); n++; end
    check("wait_to_frame", 32'(n < 20), 32'd1);
    check("to_first_ch", 32'(bus.adc_ch), 32'd0);
    n = 0;
    while (bus.adc_enable === 1'b1 && n < 100) begin tick(); n++; end
    check("to_convert_cycles", 32'(n), 32'd40);
    check("to_err_set", 32'(timeout_err), 32'd1);
    n = 0;
    while (bus.adc_enable !== 1'b1 && n < 20) begin tick(); n++; end
    check("wait_to_next", 32'(n < 20), 32'd1);
    check("to_next_ch", 32'(bus.adc_ch), 32'd3);
    scan_en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin tick(); n++; end
    check("wait_idle2", 32'(n < 100), 32'd1);

    // Reset ten cycles into CONVERT
    mode = MODE_CHX; ch_mask = 8'h04; scan_en = 1'b1;
    n = 0;
    while (bus.adc_enable !== 1'b1 && n < 20) begin tick(); n++; end
    check("wait_rst_frame", 32'(n < 20), 32'd1);
    repeat (10) tick();
    rst = 1'b1; rd_ch = 3'd5;
    tick();
    check("rst_enable", 32'(bus.adc_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_bank", 32'(rd_data), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    scan_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (30) tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    // Single-channel mask: back-to-back ch0 frames
    ch_mask = 8'h01;
    push_exp(3'd0, 10'd0);
    push_exp(3'd0, 10'd0);
    push_exp(3'd0, 10'd0);
    scan_en = 1'b1;
    n = 0; low = 0; seen = 1'b0;
    while (q.size() != 0 && n < 300) begin
      tick(); n++;
      if (bus.adc_enable === 1'b1) begin
        if (seen && low > 0) begin
          check("gap_low_ge2", 32'(low >= 2), 32'd1);
          check("gap_ch", 32'(bus.adc_ch), 32'd0);
        end
        seen = 1'b1;
        low  = 0;
      end else begin
        low++;
      end
    end
    check("wait_single_drain", 32'(n < 300), 32'd1);
    scan_en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin tick(); n++; end
    check("wait_idle3", 32'(n < 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
